collision_manager: RTL
======================

COLLISION_MANAGER -- requirements
Module: collision_manager

Interface
REQ-001 SHALL have parameter NUM_SHOTS, default 3: number of independent shot drawing channels.
REQ-002 SHALL have parameter NUM_ENEMIES, default 4: number of independent enemy drawing channels.
REQ-003 SHALL have parameter SCORE_W, default 8: width of the hit score counter.
REQ-004 clk  input  1  single system clock, all logic on rising edge.
REQ-005 resetN  input  1  asynchronous active-low reset.
REQ-006 startOfFrame  input  1  one-cycle pulse at start of each frame.
REQ-007 drawing_request_shot  input  NUM_SHOTS  per-shot pixel-active flags for current pixel.
REQ-008 drawing_request_enemy  input  NUM_ENEMIES  per-enemy pixel-active flags.
REQ-009 drawing_request_tower  input  1  tower pixel-active flag.
REQ-010 ShotEnemyHit  output  NUM_SHOTS  one-cycle pulse per shot, first shot/enemy overlap in frame.
REQ-011 EnemyHit  output  NUM_ENEMIES  one-cycle pulse per enemy, first shot overlap in frame.
REQ-012 ShotTowerHit  output  NUM_SHOTS  one-cycle pulse per shot, first shot/tower overlap in frame.
REQ-013 TowerEnemyHit  output  1  one-cycle pulse, first tower/any-enemy overlap in frame.
REQ-014 FrameEnemyMask  output  NUM_ENEMIES  enemies hit during previous complete frame.
REQ-015 Score  output  SCORE_W  saturating count of enemy-hit pulses since reset.

Function
REQ-016 Raw overlap per (shot s, enemy e) pair SHALL be drawing_request_shot[s] AND drawing_request_enemy[e], evaluated every cycle.
REQ-017 Each pulse output SHALL have a sticky per-frame flag; pulse asserts one cycle after the first raw overlap of the frame (registered, latency 1), flag then set.
REQ-018 While a flag is set, further raw overlaps for that output SHALL produce no pulse until flags clear.
REQ-019 On startOfFrame all sticky flags SHALL clear; an overlap in the same cycle as startOfFrame SHALL count as first event of the new frame (pulse next cycle, flag set).
REQ-020 ShotEnemyHit[s] pulse = first cycle of frame where shot s overlaps any enemy; EnemyHit[e] likewise for enemy e overlapping any shot.
REQ-021 Multiple shots/enemies overlapping in one cycle SHALL pulse all corresponding bits in the same cycle.
REQ-022 On startOfFrame, FrameEnemyMask SHALL load the EnemyHit sticky flags accumulated in the ending frame (before clearing), valid next cycle, held until next startOfFrame.
REQ-023 Score SHALL add popcount of EnemyHit pulses each cycle, saturating at 2^SCORE_W-1, never wrapping.
REQ-024 Inputs with no overlap SHALL leave all pulses at 0; tower overlaps SHALL not affect Score.

Reset
REQ-025 Asynchronous assertion of resetN low SHALL clear all sticky flags, all pulse outputs, FrameEnemyMask and Score to 0 immediately.
REQ-026 Reset mid-frame SHALL discard accumulated flags; after release, first overlap pulses even without a prior startOfFrame.

Structure
REQ-027 Parameter defaults (NUM_SHOTS, NUM_ENEMIES, SCORE_W) SHALL live in shared package collision_pkg.
REQ-028 Sticky-flag/pulse logic SHALL be one sub-module, hit_pulse_latch (inputs raw, startOfFrame; outputs pulse, flag), instantiated per pulse bit via generate.

Verification
REQ-029 shot[0] and enemy[2] high 5 consecutive cycles -> ShotEnemyHit=001, EnemyHit=0100 for exactly one cycle, Score=1.
REQ-030 overlap again later same frame, then startOfFrame, then overlap -> no pulse mid-frame; one pulse after new frame; FrameEnemyMask=0100 after startOfFrame.
REQ-031 overlap coincident with startOfFrame -> pulse next cycle, second overlap in that frame silent.
REQ-032 shots 0,1 and enemies 1,3 simultaneously high -> ShotEnemyHit=011, EnemyHit=1010 same cycle, Score +2.
REQ-033 SCORE_W=2, four separate frames with hits -> Score 1,2,3,3 (saturates).
REQ-034 resetN low mid-frame after a hit -> all outputs 0 asynchronously; after release repeated overlap pulses once.

Source files
------------

// File: rtl/collision_pkg.sv
// Shared defaults for the collision manager: channel counts and score width.
package collision_pkg;

   localparam int NUM_SHOTS_DEF   = 3;
   localparam int NUM_ENEMIES_DEF = 4;
   localparam int SCORE_W_DEF     = 8;

endpackage : collision_pkg

// File: rtl/collision_manager_hit_pulse_latch.sv
// One-per-frame hit detector: registered pulse on the first raw overlap of a
// frame, then a sticky flag suppresses further pulses until the next frame.
module hit_pulse_latch (
   input  logic clk,
   input  logic resetN,
   input  logic raw,
   input  logic startOfFrame,
   output logic pulse,
   output logic flag
);

   logic flag_live;
   logic pulse_d, pulse_q;
   logic flag_d,  flag_q;

   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      // An overlap in the start-of-frame cycle belongs to the new frame.
      flag_live = flag_q & ~startOfFrame;
      pulse_d   = raw & ~flag_live;
      flag_d    = flag_live | raw;
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         pulse_q <= 1'b0;
         flag_q  <= 1'b0;
      end else begin
         pulse_q <= pulse_d;
         flag_q  <= flag_d;
      end
   end

   assign pulse = pulse_q;
   assign flag  = flag_q;

endmodule : hit_pulse_latch

// File: rtl/collision_manager.sv
// Per-frame shot/enemy/tower collision pulses, last-frame enemy hit mask and a
// saturating score of enemy hits.
module collision_manager
   import collision_pkg::*;
#(
   parameter int NUM_SHOTS   = NUM_SHOTS_DEF,
   parameter int NUM_ENEMIES = NUM_ENEMIES_DEF,
   parameter int SCORE_W     = SCORE_W_DEF
) (
   input  logic                   clk,
   input  logic                   resetN,
   input  logic                   startOfFrame,
   input  logic [NUM_SHOTS-1:0]   drawing_request_shot,
   input  logic [NUM_ENEMIES-1:0] drawing_request_enemy,
   input  logic                   drawing_request_tower,
   output logic [NUM_SHOTS-1:0]   ShotEnemyHit,
   output logic [NUM_ENEMIES-1:0] EnemyHit,
   output logic [NUM_SHOTS-1:0]   ShotTowerHit,
   output logic                   TowerEnemyHit,
   output logic [NUM_ENEMIES-1:0] FrameEnemyMask,
   output logic [SCORE_W-1:0]     Score
);

   localparam int CNT_W = $clog2(NUM_ENEMIES + 1);
   localparam int SUM_W = SCORE_W + CNT_W;
   localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

   logic                   any_shot, any_enemy;
   logic [NUM_SHOTS-1:0]   shot_enemy_flag, shot_tower_flag;
   logic [NUM_ENEMIES-1:0] enemy_flag;
   logic                   tower_enemy_flag;
   logic                   unused_flags;

   logic [NUM_ENEMIES-1:0] mask_d, mask_q;
   logic [SCORE_W-1:0]     score_d, score_q;
   logic [CNT_W-1:0]       hit_cnt;
   logic [SUM_W-1:0]       score_sum;

   assign any_shot  = |drawing_request_shot;
   assign any_enemy = |drawing_request_enemy;

   for (genvar s = 0; s < NUM_SHOTS; s++) begin : g_shot
      hit_pulse_latch u_shot_enemy (
         .clk          (clk),
         .resetN       (resetN),
         .raw          (drawing_request_shot[s] & any_enemy),
         .startOfFrame (startOfFrame),
         .pulse        (ShotEnemyHit[s]),
         .flag         (shot_enemy_flag[s])
      );
      hit_pulse_latch u_shot_tower (
         .clk          (clk),
         .resetN       (resetN),
         .raw          (drawing_request_shot[s] & drawing_request_tower),
         .startOfFrame (startOfFrame),
         .pulse        (ShotTowerHit[s]),
         .flag         (shot_tower_flag[s])
      );
   end

   for (genvar e = 0; e < NUM_ENEMIES; e++) begin : g_enemy
      hit_pulse_latch u_enemy (
         .clk          (clk),
         .resetN       (resetN),
         .raw          (drawing_request_enemy[e] & any_shot),
         .startOfFrame (startOfFrame),
         .pulse        (EnemyHit[e]),
         .flag         (enemy_flag[e])
      );
   end

   hit_pulse_latch u_tower_enemy (
      .clk          (clk),
      .resetN       (resetN),
      .raw          (drawing_request_tower & any_enemy),
      .startOfFrame (startOfFrame),
      .pulse        (TowerEnemyHit),
      .flag         (tower_enemy_flag)
   );

   // Only the enemy flags feed the frame mask; the rest are informational.
   assign unused_flags = ^{shot_enemy_flag, shot_tower_flag, tower_enemy_flag};

   always_comb begin
      mask_d  = startOfFrame ? enemy_flag : mask_q;
      hit_cnt = '0;
      for (int e = 0; e < NUM_ENEMIES; e++) begin
         hit_cnt = hit_cnt + CNT_W'(EnemyHit[e]);
      end
      score_sum = SUM_W'(score_q) + SUM_W'(hit_cnt);
      score_d   = (score_sum > SUM_W'(SCORE_MAX)) ? SCORE_MAX : score_sum[SCORE_W-1:0];
   end

   // NOTE: only control/state registers exist here, so all are cleared by the async reset.
   always_ff @(posedge clk or negedge resetN) begin
      if (!resetN) begin
         mask_q  <= '0;
         score_q <= '0;
      end else begin
         mask_q  <= mask_d;
         score_q <= score_d;
      end
   end

   assign FrameEnemyMask = mask_q;
   assign Score          = score_q;

endmodule : collision_manager
